// File: rtl/decoder_scoreboard_if.sv
// rtl/decoder_scoreboard_if.sv - writeback/issue/source-check bundle for decoder_scoreboard
interface decoder_scoreboard_if #(
  parameter int ADDR_W = 5
);
  localparam int N = 1 << ADDR_W;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [N-1:0]      wr_onehot;
  logic [N-1:0]      busy;
  logic [ADDR_W:0]   busy_cnt;
  logic              hazard;

  modport master (
    output wr_valid, wr_addr, iss_valid, iss_addr, rs1_addr, rs2_addr,
    input  wr_onehot, busy, busy_cnt, hazard
  );

  modport slave (
    input  wr_valid, wr_addr, iss_valid, iss_addr, rs1_addr, rs2_addr,
    output wr_onehot, busy, busy_cnt, hazard
  );
endinterface

// File: rtl/decoder_scoreboard.sv
// rtl/decoder_scoreboard.sv - one-hot writeback decoder with pending-write scoreboard
module decoder_scoreboard #(
  parameter int ADDR_W    = 5,
  parameter int ZERO_MASK = 1,
  parameter int REG_OUT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_scoreboard_if.slave  bus
);
  localparam int N  = 1 << ADDR_W;
  localparam int CW = ADDR_W + 1;

  logic [N-1:0]  onehot_d;
  logic [N-1:0]  set_vec;
  logic [N-1:0]  busy_q, busy_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic          inc, dec;
  logic          rs1_haz, rs2_haz;

  // Issue wins a same-index collision, so the count only drops for bits not being re-set.
  always_comb begin
    onehot_d = '0;
    set_vec  = '0;
    if (bus.wr_valid)  onehot_d[bus.wr_addr] = 1'b1;
    if (bus.iss_valid) set_vec[bus.iss_addr] = 1'b1;
    if (ZERO_MASK != 0) begin
      onehot_d[0] = 1'b0;
      set_vec[0]  = 1'b0;
    end
    busy_d     = (busy_q & ~onehot_d) | set_vec;
    inc        = |(set_vec & ~busy_q);
    dec        = |(onehot_d & busy_q & ~set_vec);
    busy_cnt_d = busy_cnt_q + CW'(inc) - CW'(dec);
  end

  always_comb begin
    rs1_haz = busy_q[bus.rs1_addr]
              && !(bus.wr_valid && (bus.wr_addr == bus.rs1_addr))
              && !((ZERO_MASK != 0) && (bus.rs1_addr == '0));
    rs2_haz = busy_q[bus.rs2_addr]
              && !(bus.wr_valid && (bus.wr_addr == bus.rs2_addr))
              && !((ZERO_MASK != 0) && (bus.rs2_addr == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [N-1:0] onehot_q;
      always_ff @(posedge clk) begin
        if (rst) onehot_q <= '0;
        else     onehot_q <= onehot_d;
      end
      assign bus.wr_onehot = onehot_q;
    end else begin : g_comb_out
      assign bus.wr_onehot = onehot_d;
    end
  endgenerate

  assign bus.busy     = busy_q;
  assign bus.busy_cnt = busy_cnt_q;
  assign bus.hazard   = rs1_haz | rs2_haz;
endmodule

// File: tb/tb_decoder_scoreboard.sv
// tb/tb_decoder_scoreboard.sv - self-checking bench for decoder_scoreboard
module tb_decoder_scoreboard;
  localparam int NV = 34;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [NV];
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  decoder_scoreboard_if #(.ADDR_W(5)) bus ();
  decoder_scoreboard_if #(.ADDR_W(5)) bus_c ();

  decoder_scoreboard #(.ADDR_W(5), .ZERO_MASK(1), .REG_OUT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  decoder_scoreboard #(.ADDR_W(5), .ZERO_MASK(1), .REG_OUT(0)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c.slave)
  );

  assign bus_c.wr_valid  = bus.wr_valid;
  assign bus_c.wr_addr   = bus.wr_addr;
  assign bus_c.iss_valid = bus.iss_valid;
  assign bus_c.iss_addr  = bus.iss_addr;
  assign bus_c.rs1_addr  = bus.rs1_addr;
  assign bus_c.rs2_addr  = bus.rs2_addr;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    bus.wr_valid  = 1'b0;
    bus.iss_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.iss_valid = 1'b1;
    bus.iss_addr  = a;
  endtask

  task automatic wback(input logic [4:0] a);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
  endtask

  task automatic check_state(input string name, input logic [31:0] b, input logic [31:0] c);
    check({name, "_busy"}, bus.busy, b);
    check({name, "_cnt"}, 32'(bus.busy_cnt), c);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      vecs[i].wv  = 1'b1;
      vecs[i].wa  = 5'(i);
      vecs[i].exp = (i == 0) ? 32'h0 : (32'h1 << i);
    end
    vecs[32].wv = 1'b0; vecs[32].wa = 5'd9; vecs[32].exp = 32'h0;
    vecs[33].wv = 1'b0; vecs[33].wa = 5'd0; vecs[33].exp = 32'h0;

    rst = 1'b1;
    idle();
    bus.wr_addr  = '0;
    bus.iss_addr = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    repeat (2) @(negedge clk);
    check_state("reset", 32'h0, 0);
    check("reset_onehot", bus.wr_onehot, 32'h0);
    check("reset_hazard", 32'(bus.hazard), 0);
    rst = 1'b0;

    // decode sweep: registered output lags the drive by one cycle
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        check("onehot_reg", bus.wr_onehot, exp_v);
      end
      if (i < NV) begin
        bus.wr_valid = vecs[i].wv;
        bus.wr_addr  = vecs[i].wa;
        exp_q.push_back(vecs[i].exp);
        #1 check("onehot_comb", bus_c.wr_onehot, vecs[i].exp);
      end
      @(negedge clk);
    end
    idle();
    #1 check_state("after_sweep", 32'h0, 0);

    @(negedge clk); issue(5'd5);
    @(negedge clk); issue(5'd7);
    @(negedge clk); idle(); bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
    #1 check("haz_rs1_5", 32'(bus.hazard), 1);
    check_state("two_issued", 32'h0000_00A0, 2);
    wback(5'd5);
    #1 check("bypass_rs1_5", 32'(bus.hazard), 0);
    @(negedge clk); idle();
    #1 check_state("wb5", 32'h0000_0080, 1);
    check("haz_after_wb5", 32'(bus.hazard), 0);

    @(negedge clk); issue(5'd9);
    @(negedge clk); issue(5'd9); wback(5'd9);
    @(negedge clk); idle();
    #1 check_state("collide9", 32'h0000_0280, 2);
    issue(5'd3); wback(5'd7);
    @(negedge clk); idle();
    #1 check_state("iss3_wb7", 32'h0000_0208, 2);

    issue(5'd12);
    @(negedge clk); idle(); bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd12;
    #1 check("haz_rs2_12", 32'(bus.hazard), 1);
    wback(5'd12);
    #1 check("bypass_rs2_12", 32'(bus.hazard), 0);
    @(negedge clk); idle();
    #1 check_state("wb12", 32'h0000_0208, 2);
    issue(5'd0); bus.rs2_addr = 5'd0;
    @(negedge clk); idle();
    #1 check_state("iss0", 32'h0000_0208, 2);
    check("haz_rs0", 32'(bus.hazard), 0);

    bus.rs1_addr = 5'd4; issue(5'd4);
    #1 check("haz_ignores_iss", 32'(bus.hazard), 0);
    @(negedge clk); idle();
    #1 check("haz_rs1_4", 32'(bus.hazard), 1);
    check_state("iss4", 32'h0000_0218, 3);
    wback(5'd20);
    @(negedge clk); idle();
    #1 check_state("wb_nonbusy", 32'h0000_0218, 3);

    for (int i = 1; i < 32; i++) begin
      @(negedge clk); issue(5'(i));
    end
    @(negedge clk); idle();
    #1 check_state("fill", 32'hFFFF_FFFE, 31);

    rst = 1'b1; issue(5'd5); wback(5'd6);
    @(negedge clk);
    #1 check_state("rst_override", 32'h0, 0);
    check("rst_onehot", bus.wr_onehot, 32'h0);
    rst = 1'b0; idle();
    for (int i = 0; i < 3; i++) begin
      bus.rs1_addr = 5'(i * 10 + 1);
      bus.rs2_addr = 5'(31 - i);
      #1 check("post_rst_hazard", 32'(bus.hazard), 0);
    end
    @(negedge clk); issue(5'd2);
    @(negedge clk); idle();
    #1 check_state("first_issue", 32'h0000_0004, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/decoder_scoreboard.md
DECODER_SCOREBOARD -- requirements
Module: decoder_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5; address width, N = 2**ADDR_W entries.
REQ-002 SHALL have parameter ZERO_MASK, default 1; 1 = entry 0 is hardwired and never decoded, marked or reported.
REQ-003 SHALL have parameter REG_OUT, default 1; 1 = wr_onehot is registered, 0 = wr_onehot is combinational.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_valid  in  1  writeback request this cycle.
REQ-007 wr_addr  in  ADDR_W  writeback destination index.
REQ-008 iss_valid  in  1  issue request; marks destination pending.
REQ-009 iss_addr  in  ADDR_W  issue destination index.
REQ-010 rs1_addr, rs2_addr  in  ADDR_W  source indices to check.
REQ-011 wr_onehot  out  N  decoded one-hot write enable.
REQ-012 busy  out  N  registered pending-write vector.
REQ-013 busy_cnt  out  ADDR_W+1  registered population count of busy.
REQ-014 hazard  out  1  combinational: a source is pending and not being resolved this cycle.

Function
REQ-015 Decode SHALL set wr_onehot[wr_addr]=1 and all other bits 0 when wr_valid=1; all bits 0 when wr_valid=0.
REQ-016 With ZERO_MASK=1, wr_onehot[0] SHALL be 0 for every input value.
REQ-017 With REG_OUT=1, wr_onehot SHALL reflect cycle-T inputs in cycle T+1 (1-cycle latency); with REG_OUT=0, latency SHALL be 0.
REQ-018 busy[iss_addr] SHALL set at the next edge when iss_valid=1, except index 0 when ZERO_MASK=1.
REQ-019 busy[wr_addr] SHALL clear at the next edge when wr_valid=1.
REQ-020 When iss_valid and wr_valid are both 1 with iss_addr==wr_addr, set SHALL win: the bit is 1 after the edge.
REQ-021 When iss_valid and wr_valid are both 1 with different addresses, both updates SHALL apply in the same edge.
REQ-022 Issue to an already-busy index SHALL leave it busy, with no count change; writeback to a non-busy index SHALL be a no-op.
REQ-023 busy_cnt SHALL equal popcount(busy) every cycle; range 0..N-1 with ZERO_MASK=1, 0..N otherwise; it SHALL never wrap.
REQ-024 busy_cnt SHALL change by -1, 0 or +1 per cycle, consistent with REQ-018..REQ-022.
REQ-025 hazard SHALL be 1 iff, for rs1_addr or rs2_addr: busy[rsX]=1, AND NOT (wr_valid=1 and wr_addr==rsX); i.e. same-cycle writeback bypasses.
REQ-026 Source index 0 SHALL never raise hazard when ZERO_MASK=1.
REQ-027 hazard SHALL depend only on current busy and current wr_*/rs* inputs, not on the iss_* inputs.

Reset
REQ-028 While rst=1 at an edge, busy, busy_cnt and registered wr_onehot SHALL be 0 after that edge, overriding any concurrent iss_valid/wr_valid.
REQ-029 Reset asserted mid-operation SHALL discard all pending marks; the first issue after deassertion SHALL give busy_cnt=1.
REQ-030 hazard SHALL be 0 in the cycle following reset for all rs inputs, with wr_valid=0.

Verification (ADDR_W=5, ZERO_MASK=1, REG_OUT=1)
REQ-031 Decode sweep: wr_valid=1 with wr_addr=1..31 -> next cycle wr_onehot=32'h1<<addr; wr_addr=0 -> 32'h0; wr_valid=0 -> 32'h0.
REQ-032 Scoreboard: issue 5, issue 7, then rs1=5 -> hazard=1, busy=32'h0000_00A0, busy_cnt=2; writeback 5 -> busy=32'h0000_0080, busy_cnt=1.
REQ-033 Collisions: iss_addr=wr_addr=9 with 9 busy -> stays busy, cnt unchanged; issue 3 plus writeback 7 in one cycle -> busy[3]=1, busy[7]=0, cnt unchanged.
REQ-034 Bypass and zero entry: busy[12]=1, rs2=12, wr_valid=1, wr_addr=12 -> hazard=0 that cycle; issue 0 -> busy[0]=0, cnt unchanged.
REQ-035 Fill/reset: issue 1..31 -> busy=32'hFFFF_FFFE, cnt=31; rst=1 with iss_valid=1 -> busy=0, cnt=0, wr_onehot=0.
